// File: rtl/cmd_sched_pkg.sv
// cmd_pkg: shared types and constants for the command scheduler.
//   state_t : scheduler FSM states
//   src_t   : granted command source
//   CMD_*   : opcodes the scheduler generates on its own
//   wd_tc() : watchdog terminal count for a given FAST_SIM setting
package cmd_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
  typedef enum logic [1:0] {SRC_RMT, SRC_AUX, SRC_WD} src_t;

  localparam logic [7:0]  CMD_EMER_LAND = 8'h08;
  localparam logic [15:0] EMER_DATA     = 16'h0000;

  localparam int WD_W = 26;

  // Terminal count is the value held once saturated; reaching it from 0
  // takes 2^16 (FAST_SIM) or 2^26 cycles including the clearing edge.
  function automatic logic [WD_W-1:0] wd_tc(input int fast_sim);
    return (fast_sim != 0) ? 26'h000_FFFF : 26'h3FF_FFFF;
  endfunction

endpackage

// File: rtl/cmd_sched_if.sv
// cmd_sched_if: command-source / cmd_cfg handshake bundle.
//   rmt_*  : remote link request + payload, clr_rmt_rdy acknowledge
//   aux_*  : auxiliary source request + payload, clr_aux_rdy acknowledge
//   cmd_rdy/cmd/data, clr_cmd_rdy, send_resp : cmd_cfg side
//   resp_to_rmt/resp_to_aux/resp_drop : response routing pulses
//   wdog_trip, busy : status
// slave = scheduler view, master = environment view.
interface cmd_sched_if;
  logic        rmt_rdy;
  logic [7:0]  rmt_cmd;
  logic [15:0] rmt_data;
  logic        clr_rmt_rdy;
  logic        aux_rdy;
  logic [7:0]  aux_cmd;
  logic [15:0] aux_data;
  logic        clr_aux_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        resp_to_rmt;
  logic        resp_to_aux;
  logic        resp_drop;
  logic        wdog_trip;
  logic        busy;

  modport slave (
    input  rmt_rdy, rmt_cmd, rmt_data, aux_rdy, aux_cmd, aux_data,
           clr_cmd_rdy, send_resp,
    output clr_rmt_rdy, clr_aux_rdy, cmd_rdy, cmd, data,
           resp_to_rmt, resp_to_aux, resp_drop, wdog_trip, busy
  );

  modport master (
    output rmt_rdy, rmt_cmd, rmt_data, aux_rdy, aux_cmd, aux_data,
           clr_cmd_rdy, send_resp,
    input  clr_rmt_rdy, clr_aux_rdy, cmd_rdy, cmd, data,
           resp_to_rmt, resp_to_aux, resp_drop, wdog_trip, busy
  );
endinterface

// File: rtl/cmd_sched_wdog.sv
// cmd_wdog: remote comm-loss watchdog.
//   clk, rst  : clock, async active-high reset
//   kick      : remote grant, restarts the count and clears wdog_trip
//   svc       : watchdog injection granted, clears wd_pend
//   wd_pend   : emergency-land injection requested
//   wdog_trip : comm loss detected (level)
module cmd_wdog
  import cmd_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  input  logic svc,
  output logic wd_pend,
  output logic wdog_trip
);

  localparam logic [WD_W-1:0] TC = wd_tc(FAST_SIM);

  logic [WD_W-1:0] wd_cnt_q;
  logic            pend_q;
  logic            trip_q;

  // Pend/trip are set only on the step into TC, so a saturated counter
  // cannot re-request injection after svc. kick wins over that step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      pend_q   <= 1'b0;
      trip_q   <= 1'b0;
    end else begin
      if (svc) pend_q <= 1'b0;
      if (kick) begin
        wd_cnt_q <= '0;
        trip_q   <= 1'b0;
      end else if (wd_cnt_q != TC) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
        if (wd_cnt_q == TC - 1'b1) begin
          pend_q <= 1'b1;
          trip_q <= 1'b1;
        end
      end
    end
  end

  assign wd_pend   = pend_q;
  assign wdog_trip = trip_q;

endmodule

// File: rtl/cmd_sched.sv
// cmd_sched: arbitrates remote and auxiliary command sources onto the
// cmd_cfg handshake and routes responses back to the originator.
//   clk, rst : clock, async active-high reset
//   bus      : cmd_sched_if.slave (requests, cmd_cfg handshake, status)
// Parameters: FAST_SIM (watchdog terminal count), RESP_TMO (response timeout).
// Build macro CMD_SCHED_WDOG_EN compiles in the comm-loss watchdog; without
// it wdog_trip is 0 and only RMT/AUX are granted.
module cmd_sched
  import cmd_pkg::*;
#(
  parameter int FAST_SIM = 1,
  parameter int RESP_TMO = 1024
) (
  input  logic       clk,
  input  logic       rst,
  cmd_sched_if.slave bus
);

  localparam int TW = (RESP_TMO > 1) ? $clog2(RESP_TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TMO - 1);

  state_t      state_q;
  src_t        src_q;
  src_t        last_gnt_q;
  logic [7:0]  cmd_q;
  logic [15:0] data_q;
  logic        cmd_rdy_q;
  logic        resp_rmt_q;
  logic        resp_aux_q;
  logic        resp_drop_q;
  logic [TW-1:0] tmo_q;

  logic        gnt_vld;
  src_t        gnt_src;
  logic [7:0]  gnt_cmd;
  logic [15:0] gnt_data;

`ifdef CMD_SCHED_WDOG_EN
  logic wd_pend;
  logic wdog_trip;
  logic kick;
  logic svc;

  assign kick = gnt_vld && (gnt_src == SRC_RMT);
  assign svc  = gnt_vld && (gnt_src == SRC_WD);

  cmd_wdog #(.FAST_SIM(FAST_SIM)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .kick      (kick),
    .svc       (svc),
    .wd_pend   (wd_pend),
    .wdog_trip (wdog_trip)
  );
  assign bus.wdog_trip = wdog_trip;
`else
  logic unused_fast_sim;
  assign unused_fast_sim = (FAST_SIM != 0);
  assign bus.wdog_trip   = 1'b0;
`endif

  // Grant decode is combinational so clr_*_rdy lands in the request cycle.
  // Masked by rst so a held request does not pulse clr_* during reset.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = SRC_RMT;
    if (state_q == IDLE && !rst) begin
`ifdef CMD_SCHED_WDOG_EN
      if (wd_pend) begin
        gnt_vld = 1'b1;
        gnt_src = SRC_WD;
      end else
`endif
      if (bus.rmt_rdy && bus.aux_rdy) begin
        gnt_vld = 1'b1;
        gnt_src = (last_gnt_q == SRC_RMT) ? SRC_AUX : SRC_RMT;
      end else if (bus.rmt_rdy) begin
        gnt_vld = 1'b1;
        gnt_src = SRC_RMT;
      end else if (bus.aux_rdy) begin
        gnt_vld = 1'b1;
        gnt_src = SRC_AUX;
      end
    end
  end

  always_comb begin
    gnt_cmd  = bus.rmt_cmd;
    gnt_data = bus.rmt_data;
    if (gnt_src == SRC_AUX) begin
      gnt_cmd  = bus.aux_cmd;
      gnt_data = bus.aux_data;
    end else if (gnt_src == SRC_WD) begin
      gnt_cmd  = CMD_EMER_LAND;
      gnt_data = EMER_DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= SRC_RMT;
      last_gnt_q  <= SRC_AUX;
      cmd_q       <= '0;
      data_q      <= '0;
      cmd_rdy_q   <= 1'b0;
      resp_rmt_q  <= 1'b0;
      resp_aux_q  <= 1'b0;
      resp_drop_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      resp_rmt_q  <= 1'b0;
      resp_aux_q  <= 1'b0;
      resp_drop_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            src_q     <= gnt_src;
            cmd_q     <= gnt_cmd;
            data_q    <= gnt_data;
            cmd_rdy_q <= 1'b1;
            state_q   <= ISSUE;
            // Round-robin only tracks the two real requesters.
            if (gnt_src != SRC_WD) last_gnt_q <= gnt_src;
          end
        end
        ISSUE: begin
          if (bus.clr_cmd_rdy) begin
            cmd_rdy_q <= 1'b0;
            tmo_q     <= '0;
            if (bus.send_resp) begin
              resp_rmt_q <= (src_q == SRC_RMT);
              resp_aux_q <= (src_q == SRC_AUX);
              state_q    <= IDLE;
            end else begin
              state_q <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (bus.send_resp) begin
            resp_rmt_q <= (src_q == SRC_RMT);
            resp_aux_q <= (src_q == SRC_AUX);
            state_q    <= IDLE;
          end else if (tmo_q == TMO_LAST) begin
            resp_drop_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.clr_rmt_rdy = gnt_vld && (gnt_src == SRC_RMT);
  assign bus.clr_aux_rdy = gnt_vld && (gnt_src == SRC_AUX);
  assign bus.cmd_rdy     = cmd_rdy_q;
  assign bus.cmd         = cmd_q;
  assign bus.data        = data_q;
  assign bus.resp_to_rmt = resp_rmt_q;
  assign bus.resp_to_aux = resp_aux_q;
  assign bus.resp_drop   = resp_drop_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/cmd_sched.md
# cmd_sched

Command scheduler between the command sources and `cmd_cfg`. It arbitrates two command producers: the remote link (UART wrapper) and the on-board auxiliary source (autopilot/test sequencer). It presents one command at a time on `cmd_cfg`'s `cmd_rdy/cmd/data` handshake and routes the returned `send_resp` to the originating source. A comm-loss watchdog injects an emergency-land command when the remote goes silent.

## Interface
Parameters:
- `FAST_SIM`, 1, selects the watchdog terminal count: 2^16 cycles when 1, 2^26 cycles when 0.
- `RESP_TMO`, 1024, maximum cycles to wait for `send_resp` after a command is consumed.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rmt_rdy` in 1: remote command valid. `rmt_cmd` in 8 and `rmt_data` in 16 carry its payload.
- `clr_rmt_rdy` out 1: one-cycle pulse when the remote command is latched.
- `aux_rdy` in 1: auxiliary command valid. `aux_cmd` in 8 and `aux_data` in 16 carry its payload.
- `clr_aux_rdy` out 1: one-cycle pulse when the aux command is latched.
- `cmd_rdy` out 1, `cmd` out 8, `data` out 16: command presented to `cmd_cfg`.
- `clr_cmd_rdy` in 1: `cmd_cfg` has consumed the command.
- `send_resp` in 1: `cmd_cfg` response strobe.
- `resp_to_rmt` out 1 and `resp_to_aux` out 1: registered one-cycle response routing pulses.
- `resp_drop` out 1: one-cycle pulse on response timeout.
- `wdog_trip` out 1: level output, remote comm loss detected.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states are `IDLE`, `ISSUE` and `WAIT_RESP`. A 2-bit `src` register records the granted source: RMT, AUX or WD.
- IDLE grant priority:
  - `wd_pend` (pending watchdog injection) wins over both requesters.
  - If both `rmt_rdy` and `aux_rdy` are high, round-robin applies: the source not granted last wins. The `last_gnt` reset value is AUX, so RMT wins first.
  - If only one requester is ready, it is granted.
- On a grant:
  - Latch the source's cmd/data into the `cmd`/`data` registers. A WD grant latches `CMD_EMER_LAND` (8'h08) with data 16'h0000.
  - Pulse the matching `clr_*_rdy` in the grant cycle. There is no clear pulse for WD.
  - Go to ISSUE.
- ISSUE:
  - `cmd_rdy` is high.
  - When `clr_cmd_rdy` is seen, drop `cmd_rdy` next cycle and go to WAIT_RESP.
  - If `send_resp` arrives in the same cycle as `clr_cmd_rdy`, route it immediately and go to IDLE.
- WAIT_RESP:
  - On `send_resp`, pulse `resp_to_rmt` or `resp_to_aux` per `src`. A WD source produces no pulse. Go to IDLE.
  - A `tmo` counter runs in this state. When `tmo` reaches `RESP_TMO-1`, pulse `resp_drop` and go to IDLE.
- `send_resp` outside ISSUE and WAIT_RESP is ignored.
- Watchdog:
  - A 26-bit `wd_cnt` counts up every cycle and saturates at the terminal count.
  - A remote grant clears `wd_cnt` to 0.
  - At the terminal count, set `wd_pend` and `wdog_trip`.
  - The WD grant clears `wd_pend`, so emergency land is injected exactly once per trip.
  - `wdog_trip` clears on the next remote grant.
  - If a remote grant occurs in the same cycle `wd_cnt` reaches the terminal count, the grant wins: no trip, counter cleared.
- Reset mid-operation: all state is returned to its reset value immediately. No `clr_*` or `resp_*` pulses are produced. A command in flight is abandoned.

## Timing
- Reset values:
  - All outputs are 0: `cmd_rdy`, `cmd`, `data`, `clr_rmt_rdy`, `clr_aux_rdy`, `resp_to_rmt`, `resp_to_aux`, `resp_drop`, `wdog_trip`, `busy`.
  - State is IDLE, `wd_cnt` is 0.
- `*_rdy` (cycle N) to `clr_*_rdy` (cycle N) to `cmd_rdy` high (cycle N+1).
- `clr_cmd_rdy` (cycle M) to `cmd_rdy` low (cycle M+1).
- `send_resp` (cycle K) to `resp_to_*` (cycle K+1).
- Minimum back-to-back spacing: IDLE is revisited for at least 1 cycle between commands.
- Requesters must hold payload stable until their `clr_*_rdy` pulse.

## Configuration
- `CMD_SCHED_WDOG_EN` defined: the watchdog logic above is compiled in.
- `CMD_SCHED_WDOG_EN` undefined:
  - `wd_cnt` and `wd_pend` are removed.
  - `wdog_trip` is tied to 0.
  - Only RMT and AUX are ever granted.

## Structure
- Package `cmd_pkg` holds:
  - the `state_t` enum `{IDLE, ISSUE, WAIT_RESP}`;
  - the `src_t` enum `{SRC_RMT, SRC_AUX, SRC_WD}`;
  - the opcode constants, including `CMD_EMER_LAND = 8'h08`.
- One sub-module, `cmd_wdog`, holds the saturating counter, `wd_pend` and `wdog_trip`. Its inputs are `kick` and `svc`.

## Test plan
- Remote only: `rmt_cmd=8'h02`, `rmt_data=16'h0100` → `clr_rmt_rdy` at N, `cmd_rdy`/`cmd=8'h02`/`data=16'h0100` at N+1. `clr_cmd_rdy` then `send_resp` → `resp_to_rmt` pulse one cycle later.
- Both ready in the same cycle twice, with fresh commands each time → first grant RMT, second grant AUX. Responses routed to `resp_to_rmt` then `resp_to_aux`.
- `FAST_SIM=1`, no remote traffic for 65536 cycles → `wdog_trip=1`; `cmd=8'h08`, `data=0` issued exactly once. Its response produces no `resp_*` pulse. A subsequent remote grant clears `wdog_trip`.
- Consume but never respond, `RESP_TMO=1024` → `resp_drop` pulse 1024 cycles after entering WAIT_RESP. FSM back in IDLE, `busy=0`.
- Assert `rst` while in ISSUE → all outputs 0 in the same cycle. After release, a pending `aux_rdy` is granted normally.
- Build without `CMD_SCHED_WDOG_EN`, idle for 2^17 cycles → `wdog_trip` stays 0 and no command is issued.
